dmem_arbiter: RTL

- Shares the single-port, registered-output dmem syncram between two requesters:
  - port P: the processor load/store path.
  - port D: a debug/loader master that preloads or inspects data memory.
- Sits between the processor and dmem in the top level, on the same clock as dmem.
- P has priority; D is guaranteed forward progress by a starvation counter.
- Read data is steered back to the port that issued the read.

---
 rtl/dmem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port, registered-output dmem syncram between the processor
// load/store path (port P) and a debug/loader master (port D). P wins when both
// ports request. A starvation counter hands priority to D after MAX_WAIT
// consecutive blocked cycles. Read data comes back one cycle after the grant and
// goes only to the port that issued the read.
//
// Optional build macro: DMEM_ARB_STATS_EN
//   When defined, the block has an extra input stats_clr and an extra output
//   conflict_cnt. conflict_cnt is a saturating count of cycles in which both
//   ports request at once.
//
// Parameters:
//   ADDR_W   - dmem word-address width
//   DATA_W   - data width
//   MAX_WAIT - blocked D cycles before D gets priority (1..15)
//
// Ports:
//   clock                         dmem-domain clock, rising edge
//   reset                         asynchronous reset, active low
//   p_req/p_addr/p_wren/p_wdata   port P request
//   p_gnt                         P accepted this cycle (combinational)
//   p_rvalid/p_rdata              P read return
//   d_req/d_addr/d_wren/d_wdata   port D request
//   d_gnt                         D accepted this cycle (combinational)
//   d_rvalid/d_rdata              D read return
//   mem_address/mem_data/mem_wren drive to the dmem syncram
//   mem_q                         dmem read data, one cycle after the read
//   stats_clr, conflict_cnt       (DMEM_ARB_STATS_EN only) contention counter
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              p_wren,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wren,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
`ifdef DMEM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       conflict_cnt,
`endif
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic {
        P_PRIO = 1'b0,
        D_PRIO = 1'b1
    } arb_state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;

    // Read owner, one bit per port: bit 0 = P, bit 1 = D, 2'b00 = no read in flight.
    logic [1:0] rd_owner_reg;
    logic [1:0] rd_owner_next;

    logic [1:0] gnt;

    // ------------------------------------------------------------------
    // Grant. Both outputs are forced low while reset is held so nothing
    // reaches dmem during reset.
    // ------------------------------------------------------------------
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = reset && p_req && (!d_req || (state_reg == P_PRIO));
        gnt[1] = reset && d_req && (!p_req || (state_reg == D_PRIO));
    end

    assign p_gnt = gnt[0];
    assign d_gnt = gnt[1];

    // ------------------------------------------------------------------
    // Memory drive: the granted port passes straight through. With no
    // grant the bus is parked at zero.
    // ------------------------------------------------------------------
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (gnt[0]) begin
            mem_address = p_addr;
            mem_data    = p_wdata;
            mem_wren    = p_wren;
        end else if (gnt[1]) begin
            mem_address = d_addr;
            mem_data    = d_wdata;
            mem_wren    = d_wren;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter and priority FSM
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_next = 4'd0;
        if (d_req && !gnt[1]) begin
            wait_cnt_next = (wait_cnt_reg >= MAX_W) ? MAX_W : wait_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            P_PRIO: begin
                if (wait_cnt_next == MAX_W) begin
                    state_next = D_PRIO;
                end
            end
            D_PRIO: begin
                // D gets one win, then P takes priority back. P also takes
                // it back if D gives up its request.
                if (gnt[1] || !d_req) begin
                    state_next = P_PRIO;
                end
            end
            default: state_next = P_PRIO;
        endcase
    end

    // A read is tagged with its issuer at the grant edge. Writes leave the
    // owner clear, so they produce no rvalid.
    always_comb begin
        rd_owner_next    = 2'b00;
        rd_owner_next[0] = gnt[0] && !p_wren;
        rd_owner_next[1] = gnt[1] && !d_wren;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= P_PRIO;
            wait_cnt_reg <= 4'd0;
            rd_owner_reg <= 2'b00;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rd_owner_reg <= rd_owner_next;
        end
    end

    // ------------------------------------------------------------------
    // Read return: mem_q goes only to the owner; the other port sees zero.
    // ------------------------------------------------------------------
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_ret
            assign rvalid[gi] = rd_owner_reg[gi];
            assign rdata[gi]  = rd_owner_reg[gi] ? mem_q : '0;
        end
    endgenerate

    assign p_rvalid = rvalid[0];
    assign p_rdata  = rdata[0];
    assign d_rvalid = rvalid[1];
    assign d_rdata  = rdata[1];

`ifdef DMEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Contention counter. The clear wins over a same-cycle increment.
    // ------------------------------------------------------------------
    logic [15:0] conflict_cnt_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_cnt_reg <= 16'd0;
        end else if (stats_clr) begin
            conflict_cnt_reg <= 16'd0;
        end else if (p_req && d_req && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule
